// File: rtl/nonce_sequencer_if.sv
// Handshake bundle between the nonce sequencer (master) and the SHA-256 engine (slave).
interface nonce_sequencer_if #(
  parameter int TOTAL_SIZE = 640
) ();
  logic [TOTAL_SIZE-1:0] msg_out;
  logic                  begin_hash;
  logic                  hash_done;
  logic [255:0]          hash_digest;

  modport master (
    output msg_out,
    output begin_hash,
    input  hash_done,
    input  hash_digest
  );

  modport slave (
    input  msg_out,
    input  begin_hash,
    output hash_done,
    output hash_digest
  );
endinterface

// File: rtl/nonce_sequencer.sv
// Nonce sweep controller: issues one hash per nonce and stops on the first digest
// strictly below target, or after the inclusive last nonce has been tried.
module nonce_sequencer #(
  parameter int TOTAL_SIZE = 640,
  parameter int NONCE_W    = 32
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic [TOTAL_SIZE-NONCE_W-1:0] header_prefix_i,
  input  logic [NONCE_W-1:0]            nonce_first_i,
  input  logic [NONCE_W-1:0]            nonce_last_i,
  input  logic [255:0]                  target_i,
  nonce_sequencer_if.master             eng,
  output logic                          busy_o,
  output logic                          found_o,
  output logic                          exhausted_o,
  output logic [NONCE_W-1:0]            found_nonce_o,
  output logic [255:0]                  found_digest_o,
  output logic [NONCE_W:0]              attempts_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_CHECK,
    S_FOUND,
    S_EXHAUSTED
  } state_e;

  state_e                        state_q;
  logic [TOTAL_SIZE-NONCE_W-1:0] prefix_q;
  logic [NONCE_W-1:0]            nonce_q;
  logic [NONCE_W-1:0]            last_q;
  logic [NONCE_W-1:0]            found_nonce_q;
  logic [255:0]                  target_q;
  logic [255:0]                  digest_q;
  logic [255:0]                  found_digest_q;
  logic [NONCE_W:0]              attempts_q;
  logic                          begin_hash_q;
  logic                          busy_q;
  logic                          found_q;
  logic                          exhausted_q;

  logic                          hit_d;
  logic [NONCE_W-1:0]            nonce_d;
  logic [NONCE_W:0]              attempts_d;

  // Nonce increment wraps naturally, which gives the first>last sweep for free.
  always_comb begin
    hit_d      = digest_q < target_q;
    nonce_d    = nonce_q + NONCE_W'(1);
    attempts_d = attempts_q + (NONCE_W+1)'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= S_IDLE;
      prefix_q       <= '0;
      nonce_q        <= '0;
      last_q         <= '0;
      target_q       <= '0;
      digest_q       <= '0;
      found_nonce_q  <= '0;
      found_digest_q <= '0;
      attempts_q     <= '0;
      begin_hash_q   <= 1'b0;
      busy_q         <= 1'b0;
      found_q        <= 1'b0;
      exhausted_q    <= 1'b0;
    end else if (abort_i) begin
      // Abort outranks start and hash_done; result registers are left as they were.
      state_q      <= S_IDLE;
      begin_hash_q <= 1'b0;
      busy_q       <= 1'b0;
      found_q      <= 1'b0;
      exhausted_q  <= 1'b0;
    end else begin
      begin_hash_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_FOUND, S_EXHAUSTED: begin
          if (start_i) begin
            prefix_q       <= header_prefix_i;
            nonce_q        <= nonce_first_i;
            last_q         <= nonce_last_i;
            target_q       <= target_i;
            attempts_q     <= '0;
            found_nonce_q  <= '0;
            found_digest_q <= '0;
            found_q        <= 1'b0;
            exhausted_q    <= 1'b0;
            busy_q         <= 1'b1;
            begin_hash_q   <= 1'b1;
            state_q        <= S_START;
          end
        end
        S_START: state_q <= S_WAIT;
        S_WAIT: begin
          if (eng.hash_done) begin
            digest_q   <= eng.hash_digest;
            attempts_q <= attempts_d;
            state_q    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (hit_d) begin
            found_nonce_q  <= nonce_q;
            found_digest_q <= digest_q;
            found_q        <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= S_FOUND;
          end else if (nonce_q == last_q) begin
            exhausted_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_EXHAUSTED;
          end else begin
            nonce_q      <= nonce_d;
            begin_hash_q <= 1'b1;
            state_q      <= S_START;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign eng.msg_out    = {prefix_q, nonce_q};
  assign eng.begin_hash = begin_hash_q;
  assign busy_o         = busy_q;
  assign found_o        = found_q;
  assign exhausted_o    = exhausted_q;
  assign found_nonce_o  = found_nonce_q;
  assign found_digest_o = found_digest_q;
  assign attempts_o     = attempts_q;

endmodule

// File: tb/tb_nonce_sequencer.sv
// Bench for nonce_sequencer: behavioural hash engine, table-driven sweeps,
// hand-written abort/reset/ignored-start sequences and randomized sweeps vs a sweep model.
module tb_nonce_sequencer;

  logic         clk;
  logic         n_rst;
  logic         start_i;
  logic         abort_i;
  logic [607:0] header_prefix_i;
  logic [31:0]  nonce_first_i;
  logic [31:0]  nonce_last_i;
  logic [255:0] target_i;
  logic         busy_o;
  logic         found_o;
  logic         exhausted_o;
  logic [31:0]  found_nonce_o;
  logic [255:0] found_digest_o;
  logic [32:0]  attempts_o;

  nonce_sequencer_if #(.TOTAL_SIZE(640)) eng ();

  nonce_sequencer #(.TOTAL_SIZE(640), .NONCE_W(32)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .header_prefix_i (header_prefix_i),
    .nonce_first_i   (nonce_first_i),
    .nonce_last_i    (nonce_last_i),
    .target_i        (target_i),
    .eng             (eng),
    .busy_o          (busy_o),
    .found_o         (found_o),
    .exhausted_o     (exhausted_o),
    .found_nonce_o   (found_nonce_o),
    .found_digest_o  (found_digest_o),
    .attempts_o      (attempts_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Engine model state: digests come from a sparse map, everything else is all-ones.
  logic [255:0] digestMap [logic [31:0]];
  logic [31:0]  issuedQ [$];
  logic [607:0] expPrefix;
  int           prefixBad;
  int           beginCount;
  int           engLatency;
  logic         pending;
  int           cnt;
  logic [31:0]  pendNonce;

  function automatic logic [255:0] digestOf(input logic [31:0] n);
    if (digestMap.exists(n)) return digestMap[n];
    return '1;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [607:0] rand608();
    logic [607:0] r;
    for (int i = 0; i < 19; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pending         <= 1'b0;
      cnt             <= 0;
      pendNonce       <= '0;
      eng.hash_done   <= 1'b0;
      eng.hash_digest <= '0;
    end else begin
      eng.hash_done <= 1'b0;
      if (eng.begin_hash) begin
        pending   <= 1'b1;
        cnt       <= engLatency;
        pendNonce <= eng.msg_out[31:0];
        issuedQ.push_back(eng.msg_out[31:0]);
        beginCount++;
        if (eng.msg_out[639:32] !== expPrefix) prefixBad++;
      end else if (pending) begin
        if (cnt <= 1) begin
          eng.hash_done   <= 1'b1;
          eng.hash_digest <= digestOf(pendNonce);
          pending         <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: walk the nonce range by the sweep rules and record what must happen.
  task automatic modelSweep(input logic [31:0] first, input logic [31:0] last,
                            input logic [255:0] tgt, output logic [31:0] seq[$],
                            output logic f, output logic e, output logic [31:0] fn,
                            output logic [255:0] fd, output logic [32:0] att);
    logic [31:0]  n;
    logic [255:0] d;
    seq = {};
    f = 1'b0; e = 1'b0; fn = '0; fd = '0; att = '0;
    n = first;
    for (int i = 0; i < 4096; i++) begin
      seq.push_back(n);
      att = att + 33'd1;
      d = digestOf(n);
      if (d < tgt) begin
        f = 1'b1; fn = n; fd = d;
        break;
      end
      if (n == last) begin
        e = 1'b1;
        break;
      end
      n = n + 32'd1;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] first, input logic [31:0] last,
                               input logic [255:0] tgt, input int lat);
    @(negedge clk);
    engLatency      = lat;
    issuedQ.delete();
    prefixBad       = 0;
    header_prefix_i = rand608();
    expPrefix       = header_prefix_i;
    nonce_first_i   = first;
    nonce_last_i    = last;
    target_i        = tgt;
    start_i         = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("beginAfterStart", eng.begin_hash, 1);
    check("busyAfterStart", busy_o, 1);
    check("msgNonceFirst", eng.msg_out[31:0], first);
    // Scramble the config inputs so only latched values can drive the sweep.
    header_prefix_i = rand608();
    nonce_first_i   = $urandom;
    nonce_last_i    = $urandom;
    target_i        = rand256();
  endtask

  task automatic waitDone();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (found_o || exhausted_o) break;
    end
    check("sweepDone", found_o | exhausted_o, 1);
  endtask

  task automatic checkOutput(input logic f, input logic e, input logic [31:0] fn,
                             input logic [255:0] fd, input logic [32:0] att,
                             input logic [31:0] seq[$]);
    int bad;
    bad = 0;
    check("found", found_o, f);
    check("exhausted", exhausted_o, e);
    check("busyDone", busy_o, 0);
    check("foundNonce", found_nonce_o, fn);
    check("foundDigest", found_digest_o, fd);
    check("attempts", attempts_o, att);
    check("nonceSeqLen", issuedQ.size(), seq.size());
    for (int i = 0; i < seq.size() && i < issuedQ.size(); i++)
      if (issuedQ[i] !== seq[i]) bad++;
    check("nonceSeqVal", bad, 0);
    check("prefix", prefixBad, 0);
    repeat (3) @(negedge clk);
    check("holdResult", {found_o, exhausted_o, attempts_o}, {f, e, att});
  endtask

  task automatic runSweep(input logic [31:0] first, input logic [31:0] last,
                          input logic [255:0] tgt, input int lat);
    logic [31:0]  seq [$];
    logic         f, e;
    logic [31:0]  fn;
    logic [255:0] fd;
    logic [32:0]  att;
    modelSweep(first, last, tgt, seq, f, e, fn, fd, att);
    applyStimulus(first, last, tgt, lat);
    waitDone();
    checkOutput(f, e, fn, fd, att, seq);
  endtask

  typedef struct {
    logic [31:0]  first;
    logic [31:0]  last;
    logic [255:0] target;
    logic [31:0]  hitNonce;
    logic [255:0] hitDigest;
    logic         expFound;
    logic         expExh;
    logic [31:0]  expNonce;
    logic [32:0]  expAttempts;
  } vec_t;

  initial begin
    vec_t         vecs [6];
    logic [255:0] tgtA;
    logic [255:0] tgtB;
    int           bc;
    logic [31:0]  first, last;
    logic [255:0] tgt;
    int           len;

    tgtA = 256'h20 << 248;
    tgtB = 256'h1234 << 200;
    vecs[0] = '{32'd5, 32'd7, tgtA, 32'd6, 256'h10 << 248, 1'b1, 1'b0, 32'd6, 33'd2};
    vecs[1] = '{32'd0, 32'd2, tgtA, 32'd0, '1, 1'b0, 1'b1, 32'd0, 33'd3};
    vecs[2] = '{32'hFFFFFFFF, 32'd1, tgtA, 32'd0, '1, 1'b0, 1'b1, 32'd0, 33'd3};
    vecs[3] = '{32'd3, 32'd3, tgtA, 32'd3, tgtA, 1'b0, 1'b1, 32'd0, 33'd1};
    vecs[4] = '{32'd3, 32'd3, tgtA, 32'd3, tgtA - 256'd1, 1'b1, 1'b0, 32'd3, 33'd1};
    vecs[5] = '{32'd9, 32'd12, tgtB, 32'd11, tgtB - 256'd1, 1'b1, 1'b0, 32'd11, 33'd3};

    n_rst           = 1'b0;
    start_i         = 1'b0;
    abort_i         = 1'b0;
    header_prefix_i = '0;
    nonce_first_i   = '0;
    nonce_last_i    = '0;
    target_i        = '0;
    expPrefix       = '0;
    prefixBad       = 0;
    beginCount      = 0;
    engLatency      = 2;
    #3;
    check("rstOutputs", {busy_o, found_o, exhausted_o, eng.begin_hash, attempts_o, found_nonce_o}, '0);
    check("rstMsg", eng.msg_out[255:0], '0);
    @(negedge clk);
    n_rst = 1'b1;

    for (int v = 0; v < 6; v++) begin
      digestMap.delete();
      digestMap[vecs[v].hitNonce] = vecs[v].hitDigest;
      runSweep(vecs[v].first, vecs[v].last, vecs[v].target, 1 + v % 3);
      check($sformatf("tbl%0dFound", v), found_o, vecs[v].expFound);
      check($sformatf("tbl%0dExh", v), exhausted_o, vecs[v].expExh);
      check($sformatf("tbl%0dNonce", v), found_nonce_o, vecs[v].expNonce);
      check($sformatf("tbl%0dAttempts", v), attempts_o, vecs[v].expAttempts);
    end

    $display("[TB] abort clears a held FOUND result");
    @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abortFromFound", {found_o, exhausted_o, busy_o}, 3'b000);

    $display("[TB] start while busy is ignored");
    digestMap.delete();
    applyStimulus(32'd0, 32'd3, tgtA, 3);
    @(negedge clk);
    nonce_first_i   = 32'd100;
    nonce_last_i    = 32'd100;
    header_prefix_i = rand608();
    start_i         = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    waitDone();
    begin
      logic [31:0] seq [$];
      seq = '{32'd0, 32'd1, 32'd2, 32'd3};
      checkOutput(1'b0, 1'b1, 32'd0, '0, 33'd4, seq);
    end

    $display("[TB] abort during WAIT with late completion");
    applyStimulus(32'd10, 32'd20, tgtA, 3);
    @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abortBusy", busy_o, 0);
    bc = beginCount;
    repeat (10) @(negedge clk);
    check("abortNoBegin", beginCount - bc, 0);
    check("abortIdle", {busy_o, found_o, exhausted_o}, 3'b000);

    $display("[TB] abort beats hash_done and start in the same cycle");
    applyStimulus(32'd40, 32'd45, tgtA, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (eng.hash_done) break;
    end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abortVsDoneAttempts", attempts_o, 0);
    check("abortVsDoneBusy", busy_o, 0);
    abort_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    start_i = 1'b0;
    check("abortVsStart", {busy_o, eng.begin_hash}, 2'b00);
    repeat (3) @(negedge clk);

    $display("[TB] randomized sweeps");
    for (int r = 0; r < 24; r++) begin
      first = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 4)) : $urandom;
      len   = $urandom_range(0, 7);
      last  = first + 32'(len);
      tgt   = rand256();
      tgt[255:248] = 8'($urandom_range(1, 60));
      digestMap.delete();
      for (int j = 0; j <= len; j++) begin
        logic [255:0] d;
        d = rand256();
        if ($urandom_range(0, 9) == 0) d = tgt;
        digestMap[first + 32'(j)] = d;
      end
      runSweep(first, last, tgt, $urandom_range(1, 4));
    end

    $display("[TB] asynchronous reset mid-sweep");
    digestMap.delete();
    applyStimulus(32'd7, 32'd12, tgtA, 1);
    repeat (5) @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check("asyncRstFlags", {busy_o, found_o, exhausted_o, eng.begin_hash}, 4'b0000);
    check("asyncRstAttempts", attempts_o, 0);
    check("asyncRstMsg", eng.msg_out[255:0], '0);
    check("asyncRstPrefix", eng.msg_out[639:384], '0);
    @(negedge clk);
    n_rst = 1'b1;
    bc = beginCount;
    repeat (4) @(negedge clk);
    check("postRstIdle", {busy_o, 32'(beginCount - bc)}, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL globalTimeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
